// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input_conditioner slice.
package input_cond_pkg;

  localparam int unsigned WIDTH_D       = 3;
  localparam int unsigned SYNC_STAGES_D = 2;
  localparam int unsigned DB_CYCLES_D   = 16;
  localparam int unsigned EVT_W         = 8;

  localparam int unsigned IDX_A = 0;
  localparam int unsigned IDX_B = 1;
  localparam int unsigned IDX_C = 2;

  typedef logic [EVT_W-1:0] evt_cnt_t;

  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bus bundle between the pad front-end (slave) and its consumer/driver (master).
interface input_cond_if
  import input_cond_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_D
) ();

  logic             en;
  logic [WIDTH-1:0] raw_in;
  logic             cnt_clr;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  evt_cnt_t         event_cnt;

  modport master (
    output en, raw_in, cnt_clr,
    input  clean_out, rise_pulse, fall_pulse, event_cnt
  );

  modport slave (
    input  en, raw_in, cnt_clr,
    output clean_out, rise_pulse, fall_pulse, event_cnt
  );

endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter, clean level and edge pulses.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_D,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned      CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced, mismatch, flip;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    synced   = sync_q[SYNC_STAGES-1];
    mismatch = synced ^ clean_q;
    flip     = en_i && mismatch && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    // en low freezes both the count and the level; the sync chain keeps running
    if (en_i) begin
      if (!mismatch) begin
        cnt_d = '0;
      end else if (flip) begin
        cnt_d   = '0;
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = flip & ~clean_q;
    fall_d = flip &  clean_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronise/debounce ui_in logic inputs; optional rise counter on bit A
// built only when INPUT_COND_EVENT_CNT_EN is defined.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_D,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_D,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input_cond_if.slave  bus
);

  logic [WIDTH-1:0] clean_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.en),
      .raw_i   (bus.raw_in[i]),
      .clean_o (clean_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i])
    );
  end

  assign bus.clean_out  = clean_w;
  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;

`ifdef INPUT_COND_EVENT_CNT_EN
  evt_cnt_t evt_q, evt_d;

  always_comb begin
    evt_d = evt_q;
    if (bus.cnt_clr) begin
      evt_d = '0;
    end else if (rise_w[IDX_A]) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.event_cnt = evt_q;
`else
  assign bus.event_cnt = '0;
`endif

endmodule
